// File: rtl/exu_wbck_ctrl.sv
// Write-back controller for the GPR file's single write port.
// Arbitrates ALU and long-pipe results into one registered write stage and
// keeps a scoreboard of outstanding long-pipe destinations for dispatch.
//
// The ALU/long-pipe arbiter has no FSM. Its only sequential state is the
// saturating ALU starvation counter.
module exu_wbck_ctrl #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int RFREG_NUM   = 32,
    parameter int OUTS_DEPTH  = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_data,

    input  logic                   longp_wbck_valid,
    output logic                   longp_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] longp_wbck_idx,
    input  logic [XLEN-1:0]        longp_wbck_data,

    input  logic                   longp_issue_valid,
    input  logic [RFIDX_WIDTH-1:0] longp_issue_idx,

    input  logic [RFIDX_WIDTH-1:0] disp_src1_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_src2_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_dest_idx,
    output logic                   disp_dep_stall,
    output logic                   outs_full,

    output logic                   wbck_dest_ena,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_data
);

    localparam int CNT_W    = $clog2(OUTS_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]    OUTS_TOP   = CNT_W'(OUTS_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    logic [RFREG_NUM-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic                   ena_q, ena_d;
    logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
    logic [XLEN-1:0]        data_q, data_d;

    logic                   alu_prio;
    logic                   alu_grant;
    logic                   longp_grant;
    logic                   any_grant;
    logic [RFIDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]        sel_data;

    logic                   retire_ok;
    logic                   issue_hit_pend;
    logic                   issue_ok;

    // Grant: long-pipe by default, ALU once it has lost STARVE_MAX times in a row.
    always_comb begin
        alu_prio    = alu_wbck_valid && (starve_q == STARVE_TOP);
        longp_grant = longp_wbck_valid && !alu_prio;
        alu_grant   = alu_wbck_valid && !longp_grant;
        any_grant   = longp_grant || alu_grant;
        sel_idx     = longp_grant ? longp_wbck_idx  : alu_wbck_idx;
        sel_data    = longp_grant ? longp_wbck_data : alu_wbck_data;
    end

    assign alu_wbck_ready   = alu_grant;
    assign longp_wbck_ready = longp_grant;

    // Starvation counter: count consecutive ALU losses, saturating.
    always_comb begin
        starve_d = '0;
        if (alu_wbck_valid && !alu_grant) begin
            starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
        end
    end

    // Output stage next state: an x0 write handshakes but never enables the port.
    always_comb begin
        ena_d  = any_grant && (sel_idx != '0);
        idx_d  = any_grant ? sel_idx  : idx_q;
        data_d = any_grant ? sel_data : data_q;
    end

    assign outs_full = (cnt_q == OUTS_TOP);

    // A full queue can still accept an issue if a slot frees in the same cycle;
    // re-issuing a pending index is only legal when that index retires now.
    always_comb begin
        retire_ok      = longp_grant && (cnt_q != '0);
        issue_hit_pend = pend_q[longp_issue_idx] && (longp_issue_idx != '0) &&
                         !(longp_grant && (longp_wbck_idx == longp_issue_idx));
        issue_ok       = longp_issue_valid && (!outs_full || retire_ok) && !issue_hit_pend;
    end

    // Scoreboard next state: retire clears first so a same-index issue wins.
    always_comb begin
        pend_d = pend_q;
        if (longp_grant) begin
            pend_d[longp_wbck_idx] = 1'b0;
        end
        if (issue_ok && (longp_issue_idx != '0)) begin
            pend_d[longp_issue_idx] = 1'b1;
        end
        pend_d[0] = 1'b0;

        case ({issue_ok, retire_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    function automatic logic hazard(input logic [RFIDX_WIDTH-1:0] q,
                                    input logic [RFREG_NUM-1:0]   pend,
                                    input logic                   ena,
                                    input logic [RFIDX_WIDTH-1:0] widx);
        return (q != '0) && (pend[q] || (ena && (widx == q)));
    endfunction

    // Dispatch hazard: pending long-pipe dest, in-flight write, or no free slot.
    always_comb begin
        disp_dep_stall = hazard(disp_src1_idx, pend_q, ena_q, idx_q) ||
                         hazard(disp_src2_idx, pend_q, ena_q, idx_q) ||
                         hazard(disp_dest_idx, pend_q, ena_q, idx_q) ||
                         outs_full;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            ena_q    <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            ena_q    <= ena_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    assign wbck_dest_ena  = ena_q;
    assign wbck_dest_idx  = idx_q;
    assign wbck_dest_data = data_q;

`ifndef SYNTHESIS
    // Upstream protocol checks: illegal issue, retire with nothing outstanding.
    a_issue_legal: assert property (@(posedge clk) disable iff (rst)
        !(longp_issue_valid && !issue_ok));
    a_retire_legal: assert property (@(posedge clk) disable iff (rst)
        !(longp_grant && (cnt_q == '0)));
`endif

endmodule

// File: tb/tb_exu_wbck_ctrl.sv
// Bench for exu_wbck_ctrl: directed stimulus, with expected regfile writes
// queued by stimulus and checked by an independent monitor.
module tb_exu_wbck_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wbck_valid, alu_wbck_ready;
    logic [4:0]  alu_wbck_idx;
    logic [31:0] alu_wbck_data;
    logic        longp_wbck_valid, longp_wbck_ready;
    logic [4:0]  longp_wbck_idx;
    logic [31:0] longp_wbck_data;
    logic        longp_issue_valid;
    logic [4:0]  longp_issue_idx;
    logic [4:0]  disp_src1_idx, disp_src2_idx, disp_dest_idx;
    logic        disp_dep_stall, outs_full;
    logic        wbck_dest_ena;
    logic [4:0]  wbck_dest_idx;
    logic [31:0] wbck_dest_data;

    exu_wbck_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .alu_wbck_valid    (alu_wbck_valid),
        .alu_wbck_ready    (alu_wbck_ready),
        .alu_wbck_idx      (alu_wbck_idx),
        .alu_wbck_data     (alu_wbck_data),
        .longp_wbck_valid  (longp_wbck_valid),
        .longp_wbck_ready  (longp_wbck_ready),
        .longp_wbck_idx    (longp_wbck_idx),
        .longp_wbck_data   (longp_wbck_data),
        .longp_issue_valid (longp_issue_valid),
        .longp_issue_idx   (longp_issue_idx),
        .disp_src1_idx     (disp_src1_idx),
        .disp_src2_idx     (disp_src2_idx),
        .disp_dest_idx     (disp_dest_idx),
        .disp_dep_stall    (disp_dep_stall),
        .outs_full         (outs_full),
        .wbck_dest_ena     (wbck_dest_ena),
        .wbck_dest_idx     (wbck_dest_idx),
        .wbck_dest_data    (wbck_dest_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_wbck_valid = 0; alu_wbck_idx = 0; alu_wbck_data = 0;
        longp_wbck_valid = 0; longp_wbck_idx = 0; longp_wbck_data = 0;
        longp_issue_valid = 0; longp_issue_idx = 0;
        disp_src1_idx = 0; disp_src2_idx = 0; disp_dest_idx = 0;
    endtask

    // Push an expected regfile write one cycle after the current handshake.
    task automatic expect_wr(input logic [4:0] idx, input logic [31:0] data);
        exp_t e;
        e.cyc = cyc + 1; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the regfile port must match the queue head or be idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_ena",  {31'd0, wbck_dest_ena}, 32'd1);
                chk("wr_idx",  {27'd0, wbck_dest_idx}, {27'd0, e.idx});
                chk("wr_data", wbck_dest_data, e.data);
            end else if (wbck_dest_ena) begin
                chk("unexpected_wr_ena", {31'd0, wbck_dest_ena}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        disp_src1_idx = 5;
        nxt(); nxt();
        chk("rst_ena",   {31'd0, wbck_dest_ena}, 0);
        chk("rst_idx",   {27'd0, wbck_dest_idx}, 0);
        chk("rst_data",  wbck_dest_data, 0);
        chk("rst_full",  {31'd0, outs_full}, 0);
        chk("rst_stall", {31'd0, disp_dep_stall}, 0);
        rst = 1'b0;
        nxt();

        // ALU-only write, then in-flight hazard on the output stage
        alu_wbck_valid = 1; alu_wbck_idx = 5; alu_wbck_data = 32'hDEADBEEF;
        #1 chk("alu_only_ready", {31'd0, alu_wbck_ready}, 1);
        chk("alu_only_lp_ready", {31'd0, longp_wbck_ready}, 0);
        expect_wr(5, 32'hDEADBEEF);
        nxt(); idle(); disp_src1_idx = 5;
        #1 chk("inflight_stall", {31'd0, disp_dep_stall}, 1);
        nxt();
        #1 chk("inflight_gone_stall", {31'd0, disp_dep_stall}, 0);

        // Contention, with x10 kept outstanding by re-issuing on each long-pipe grant
        nxt(); idle(); longp_issue_valid = 1; longp_issue_idx = 10;
        nxt(); idle();
        for (int k = 1; k <= 7; k++) begin
            nxt();
            alu_wbck_valid = 1; alu_wbck_idx = 6;
            alu_wbck_data = (k <= 4) ? 32'hA000_0001 : 32'hA000_0002;
            longp_wbck_valid = 1; longp_wbck_idx = 10; longp_wbck_data = 32'hB000_0000 + k;
            longp_issue_valid = (k != 4); longp_issue_idx = 10;
            #1 chk($sformatf("cont%0d_alu_ready", k), {31'd0, alu_wbck_ready}, (k == 4) ? 1 : 0);
            chk($sformatf("cont%0d_lp_ready", k), {31'd0, longp_wbck_ready}, (k == 4) ? 0 : 1);
            if (k == 4) expect_wr(6, 32'hA000_0001);
            else        expect_wr(10, 32'hB000_0000 + k);
        end
        nxt(); idle();
        alu_wbck_valid = 1; alu_wbck_idx = 6; alu_wbck_data = 32'hA000_0002;
        #1 chk("cont_alu_alone_ready", {31'd0, alu_wbck_ready}, 1);
        expect_wr(6, 32'hA000_0002);
        nxt(); idle(); disp_dest_idx = 10;
        longp_wbck_valid = 1; longp_wbck_idx = 10; longp_wbck_data = 32'hB000_00FF;
        #1 chk("x10_pending_stall", {31'd0, disp_dep_stall}, 1);
        chk("x10_retire_ready", {31'd0, longp_wbck_ready}, 1);
        expect_wr(10, 32'hB000_00FF);

        // Scoreboard: issue x7, retire at cycle 3
        nxt(); idle(); longp_issue_valid = 1; longp_issue_idx = 7; disp_src1_idx = 7;
        #1 chk("sb_c0_stall", {31'd0, disp_dep_stall}, 0);
        nxt(); idle(); disp_src1_idx = 7;
        #1 chk("sb_c1_stall", {31'd0, disp_dep_stall}, 1);
        nxt();
        #1 chk("sb_c2_stall", {31'd0, disp_dep_stall}, 1);
        nxt(); longp_wbck_valid = 1; longp_wbck_idx = 7; longp_wbck_data = 32'h7777_0007;
        #1 chk("sb_c3_ready", {31'd0, longp_wbck_ready}, 1);
        chk("sb_c3_stall", {31'd0, disp_dep_stall}, 1);
        expect_wr(7, 32'h7777_0007);
        nxt(); longp_wbck_valid = 0;
        #1 chk("sb_c4_stall", {31'd0, disp_dep_stall}, 1);
        nxt();
        #1 chk("sb_c5_stall", {31'd0, disp_dep_stall}, 0);

        // x0: ALU write to x0, issue to x0, retire x0
        nxt(); idle();
        alu_wbck_valid = 1; alu_wbck_idx = 0; alu_wbck_data = 32'h1234;
        longp_issue_valid = 1; longp_issue_idx = 0;
        #1 chk("x0_alu_ready", {31'd0, alu_wbck_ready}, 1);
        chk("x0_stall", {31'd0, disp_dep_stall}, 0);
        nxt(); idle();
        #1 chk("x0_pend_stall", {31'd0, disp_dep_stall}, 0);
        chk("x0_pend_full", {31'd0, outs_full}, 0);
        nxt(); longp_wbck_valid = 1; longp_wbck_idx = 0; longp_wbck_data = 32'h55;
        #1 chk("x0_lp_ready", {31'd0, longp_wbck_ready}, 1);

        // Capacity: issue x1..x4
        for (int i = 1; i <= 4; i++) begin
            nxt(); idle(); longp_issue_valid = 1; longp_issue_idx = 5'(i);
        end
        nxt(); idle();
        #1 chk("cap_full", {31'd0, outs_full}, 1);
        chk("cap_stall", {31'd0, disp_dep_stall}, 1);
        nxt(); longp_wbck_valid = 1; longp_wbck_idx = 1; longp_wbck_data = 32'h1111;
        longp_issue_valid = 1; longp_issue_idx = 9;
        #1 chk("cap_swap_ready", {31'd0, longp_wbck_ready}, 1);
        expect_wr(1, 32'h1111);
        nxt(); idle(); longp_wbck_valid = 1; longp_wbck_idx = 2; longp_wbck_data = 32'h2222;
        #1 chk("cap_still_full", {31'd0, outs_full}, 1);
        expect_wr(2, 32'h2222);
        nxt(); idle(); disp_src1_idx = 1;
        #1 chk("cap_not_full", {31'd0, outs_full}, 0);
        chk("cap_x1_clear", {31'd0, disp_dep_stall}, 0);
        disp_src1_idx = 9;
        #1 chk("cap_x9_set", {31'd0, disp_dep_stall}, 1);
        disp_src1_idx = 0; disp_src2_idx = 3;
        #1 chk("cap_x3_src2", {31'd0, disp_dep_stall}, 1);

        // Reset mid-operation
        nxt(); idle(); disp_src1_idx = 3;
        alu_wbck_valid = 1; alu_wbck_idx = 12; alu_wbck_data = 32'hCAFE_0012;
        #1 chk("pre_rst_ready", {31'd0, alu_wbck_ready}, 1);
        expect_wr(12, 32'hCAFE_0012);
        @(posedge clk); #2;
        alu_wbck_valid = 0;
        chk("pre_rst_ena", {31'd0, wbck_dest_ena}, 1);
        chk("pre_rst_stall", {31'd0, disp_dep_stall}, 1);
        rst = 1'b1;
        #1 chk("async_rst_ena", {31'd0, wbck_dest_ena}, 0);
        chk("async_rst_full", {31'd0, outs_full}, 0);
        chk("async_rst_stall", {31'd0, disp_dep_stall}, 0);
        exp_q.delete();
        nxt(); nxt();
        rst = 1'b0;
        nxt(); idle(); disp_src1_idx = 3;
        alu_wbck_valid = 1; alu_wbck_idx = 5; alu_wbck_data = 32'hDEADBEEF;
        #1 chk("post_rst_ready", {31'd0, alu_wbck_ready}, 1);
        expect_wr(5, 32'hDEADBEEF);
        nxt(); idle(); disp_src1_idx = 3;
        #1 chk("post_rst_x3_clear", {31'd0, disp_dep_stall}, 0);
        nxt(); nxt(); nxt();
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
